// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg: RV32M funct3 op encodings, muldiv FSM state encodings
// and small helpers shared by the multiply/divide unit.
package riscv_muldiv_pkg;

   localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
   localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
   localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
   localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
   localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
   localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
   localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
   localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   function automatic logic op_is_mul(input logic [2:0] op);
      return (op == MULDIV_OP_MUL) || (op == MULDIV_OP_MULH) ||
             (op == MULDIV_OP_MULHSU) || (op == MULDIV_OP_MULHU);
   endfunction

   function automatic logic op_is_rem(input logic [2:0] op);
      return (op == MULDIV_OP_REM) || (op == MULDIV_OP_REMU);
   endfunction

   function automatic logic op_is_udiv(input logic [2:0] op);
      return (op == MULDIV_OP_DIVU) || (op == MULDIV_OP_REMU);
   endfunction

   // Two's-complement negate when n is set.
   function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
      return n ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// riscv_muldiv_if: issue/writeback handshake between execute stage and the
// multiply/divide unit.
interface riscv_muldiv_if;
   logic        valid_i;
   logic        ready_o;
   logic [2:0]  op_i;
   logic [31:0] operand_a_i;
   logic [31:0] operand_b_i;
   logic        flush_i;
   logic        valid_o;
   logic [31:0] result_o;

   modport slave  (input  valid_i, op_i, operand_a_i, operand_b_i, flush_i,
                   output ready_o, valid_o, result_o);
   modport master (output valid_i, op_i, operand_a_i, operand_b_i, flush_i,
                   input  ready_o, valid_o, result_o);
endinterface

// File: rtl/riscv_divider_core.sv
// riscv_divider_core: restoring shift/subtract divider on 32-bit magnitudes.
// One quotient bit per step, MSB first. o_quot/o_rem are the values after the
// current step, so the owner can capture the final result on the last step.
module riscv_divider_core #(
   parameter int STEPS = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        i_start,
   input  logic        i_step,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic        o_last,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem
);
   logic [4:0]  r_cnt;
   logic [31:0] r_quot;
   logic [31:0] r_rem;
   logic [31:0] r_div;
   logic [32:0] w_trial;
   logic [32:0] w_diff;
   logic        w_ge;

   // Shift next dividend bit into the partial remainder and try subtracting.
   assign w_trial = {r_rem, r_quot[31]};
   assign w_diff  = w_trial - {1'b0, r_div};
   assign w_ge    = ~w_diff[32];
   assign o_quot  = {r_quot[30:0], w_ge};
   assign o_rem   = w_ge ? w_diff[31:0] : w_trial[31:0];
   assign o_last  = (r_cnt == 5'(STEPS - 1));

   // Load operands on start, otherwise advance one quotient bit per step.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_cnt  <= '0;
         r_quot <= '0;
         r_rem  <= '0;
         r_div  <= '0;
      end else if (i_start) begin
         r_cnt  <= '0;
         r_quot <= i_dividend;
         r_rem  <= '0;
         r_div  <= i_divisor;
      end else if (i_step) begin
         r_cnt  <= r_cnt + 5'd1;
         r_quot <= o_quot;
         r_rem  <= o_rem;
      end
   end
endmodule

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: multi-cycle RV32M multiply/divide unit.
// Optional feature macro RISCV_MULDIV_FAST_MUL_EN: single-cycle 33x33 signed
// multiply registered in a MUL state; default build uses a 32-step shift-add.
module riscv_muldiv
   import riscv_muldiv_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   riscv_muldiv_if.slave  bus
);
   muldiv_state_e r_state, w_state_nxt;
   logic [31:0]   r_result, w_res_nxt;
   logic [2:0]    r_op;
   logic          r_sa, r_sb;
   logic [63:0]   r_acc;

   logic [2:0]    w_op;
   logic [31:0]   w_a, w_b, w_mag_a, w_mag_b;
   logic          w_sa, w_sb, w_accept, w_ovf, w_short, w_last;
   logic [31:0]   w_short_res, w_quot, w_rem, w_mul_res, w_div_res;
   logic [63:0]   w_mprod;

   assign w_op = bus.op_i;
   assign w_a  = bus.operand_a_i;
   assign w_b  = bus.operand_b_i;

   assign bus.ready_o  = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign bus.valid_o  = (r_state == ST_DONE);
   assign bus.result_o = r_result;
   assign w_accept     = bus.valid_i && bus.ready_o && !bus.flush_i;

   // Operand signs only count for the ops that treat that operand as signed.
   assign w_sa = w_a[31] && ((w_op == MULDIV_OP_DIV) || (w_op == MULDIV_OP_REM) ||
                             (w_op == MULDIV_OP_MULH) || (w_op == MULDIV_OP_MULHSU));
   assign w_sb = w_b[31] && ((w_op == MULDIV_OP_DIV) || (w_op == MULDIV_OP_REM) ||
                             (w_op == MULDIV_OP_MULH));
   assign w_mag_a = neg_if(w_sa, w_a);
   assign w_mag_b = neg_if(w_sb, w_b);

   // Divide by zero and the one signed overflow case never iterate.
   assign w_ovf   = !op_is_udiv(w_op) && (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
   assign w_short = !op_is_mul(w_op) && ((w_b == 32'd0) || w_ovf);
   assign w_short_res = (w_b == 32'd0) ? (op_is_rem(w_op) ? w_a : 32'hFFFF_FFFF)
                                       : (op_is_rem(w_op) ? 32'd0 : 32'h8000_0000);

   riscv_divider_core #(.STEPS(MUL_CYCLES)) u_div (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .i_start    (w_accept && !w_short),
      .i_step     (r_state == ST_BUSY),
      .i_dividend (w_mag_a),
      .i_divisor  (w_mag_b),
      .o_last     (w_last),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   assign w_div_res = op_is_rem(r_op) ? neg_if(r_sa, w_rem) : neg_if(r_sa ^ r_sb, w_quot);

`ifdef RISCV_MULDIV_FAST_MUL_EN
   logic signed [63:0] w_ext_a, w_ext_b, w_fprod;
   assign w_ext_a = {{32{w_sa}}, w_a};
   assign w_ext_b = {{32{w_sb}}, w_b};
   assign w_fprod = w_ext_a * w_ext_b;
   assign w_mprod = r_acc;
`else
   // Right-shifting shift-add: high half accumulates, multiplier drains from low half.
   logic [31:0] r_mag_a;
   logic [32:0] w_msum;
   logic [63:0] w_acc_next;
   assign w_msum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
   assign w_acc_next = {w_msum, r_acc[31:1]};
   assign w_mprod    = (r_sa ^ r_sb) ? (~w_acc_next + 64'd1) : w_acc_next;
`endif

   assign w_mul_res = (r_op == MULDIV_OP_MUL) ? w_mprod[31:0] : w_mprod[63:32];

   // Handshake FSM next state and the result captured on entry to DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_res_nxt   = r_result;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.flush_i) begin
               w_state_nxt = ST_IDLE;
            end else if (bus.valid_i) begin
               if (w_short) begin
                  w_state_nxt = ST_DONE;
                  w_res_nxt   = w_short_res;
               end
`ifdef RISCV_MULDIV_FAST_MUL_EN
               else if (op_is_mul(w_op)) w_state_nxt = ST_MUL;
`endif
               else w_state_nxt = ST_BUSY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (bus.flush_i) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = ST_DONE;
               w_res_nxt   = op_is_mul(r_op) ? w_mul_res : w_div_res;
            end
         end
         ST_MUL: begin
            if (bus.flush_i) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
               w_res_nxt   = w_mul_res;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, result and operand capture registers.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
         r_op     <= '0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_acc    <= '0;
`ifndef RISCV_MULDIV_FAST_MUL_EN
         r_mag_a  <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_result <= w_res_nxt;
         if (w_accept) begin
            r_op <= w_op;
            r_sa <= w_sa;
            r_sb <= w_sb;
`ifdef RISCV_MULDIV_FAST_MUL_EN
            r_acc <= w_fprod;
`else
            r_acc   <= {32'd0, w_mag_b};
            r_mag_a <= w_mag_a;
`endif
         end
`ifndef RISCV_MULDIV_FAST_MUL_EN
         else if (r_state == ST_BUSY) begin
            r_acc <= w_acc_next;
         end
`endif
      end
   end
endmodule

// File: tb/tb_riscv_muldiv.sv
// tb_riscv_muldiv: scoreboard bench for riscv_muldiv. Stimulus pushes the
// expected result and completion cycle; a monitor checks every valid_o pulse.
module tb_riscv_muldiv;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   cyc   = 0;
   int   checks = 0;
   int   errs   = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          cyc;
   } exp_t;
   exp_t q[$];

   riscv_muldiv_if vif ();
   riscv_muldiv dut (.clk_i(clk_i), .rst_i(rst_i), .bus(vif));

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Reference results from the RV32M definitions using wide arithmetic.
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      int ia, ib;
      logic [31:0] r;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
      ia = a; ib = b;
      r = '0;
      case (op)
         3'd0: begin p = ua * ub; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 3'd4) begin
`ifdef RISCV_MULDIV_FAST_MUL_EN
         return 2;
`else
         return 33;
`endif
      end
      if (b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Called at a negedge; waits for ready, drives one cycle of valid_i.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      int n = 0;
      while (!vif.ready_o && n < 200) begin @(negedge clk_i); n++; end
      if (!vif.ready_o) begin
         checks++; errs++;
         $display("FAIL issue_timeout op=%0d ready_o=%b required 1", op, vif.ready_o);
         return;
      end
      vif.valid_i = 1'b1; vif.op_i = op; vif.operand_a_i = a; vif.operand_b_i = b;
      if (push) q.push_back('{op, a, b, ref_res(op, a, b), cyc + ref_lat(op, a, b)});
      @(negedge clk_i);
      vif.valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin @(negedge clk_i); n++; end
      if (q.size() != 0) begin
         checks++; errs++;
         $display("FAIL drain_timeout pending=%0d required 0", q.size());
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every valid_o pulse must match the oldest expectation.
   always @(negedge clk_i) begin
      if (vif.valid_o) begin
         if (q.size() == 0) begin
            checks++; errs++;
            $display("FAIL unexpected_valid cyc=%0d result=%h required no pulse", cyc, vif.result_o);
         end else begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (vif.result_o !== e.res) begin
               errs++;
               $display("FAIL result op=%0d a=%h b=%h actual=%h required=%h", e.op, e.a, e.b, vif.result_o, e.res);
            end
            checks++;
            if (cyc != e.cyc) begin
               errs++;
               $display("FAIL latency op=%0d a=%h b=%h actual_cyc=%0d required_cyc=%0d", e.op, e.a, e.b, cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      int bad;
      logic [31:0] held;
      vif.valid_i = 1'b0; vif.op_i = '0; vif.operand_a_i = '0; vif.operand_b_i = '0; vif.flush_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("reset_valid", 32'(vif.valid_o), 32'd0);
      check("reset_ready", 32'(vif.ready_o), 32'd1);
      check("reset_result", vif.result_o, 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);

      // Directed multiplies.
      issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1);
      drain();

      // DIV -7/2 with ready_o low for the 32 busy cycles.
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         if (vif.ready_o !== 1'b0) bad++;
         @(negedge clk_i);
      end
      check("busy_ready_low_count", 32'(bad), 32'd0);
      check("done_ready_high", 32'(vif.ready_o), 32'd1);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1);
      drain();

      // Short path: divide by zero and signed overflow, back to back.
      issue(3'd5, 32'd7, 32'd0, 1);
      issue(3'd7, 32'd7, 32'd0, 1);
      issue(3'd4, 32'hFFFF_FFF9, 32'd0, 1);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      drain();

      // Flush mid-divide, then REMU accepted on the edge after the flush.
      held = vif.result_o;
      issue(3'd5, 32'd100, 32'd7, 0);
      repeat (9) @(negedge clk_i);
      vif.flush_i = 1'b1;
      @(negedge clk_i);
      vif.flush_i = 1'b0;
      check("flush_ready", 32'(vif.ready_o), 32'd1);
      check("flush_result_held", vif.result_o, held);
      issue(3'd7, 32'd100, 32'd7, 1);
      drain();

      // Reset in the middle of a DIV.
      issue(3'd4, 32'hFFFF_FF9C, 32'd3, 0);
      repeat (14) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("midreset_valid", 32'(vif.valid_o), 32'd0);
      check("midreset_result", vif.result_o, 32'd0);
      check("midreset_ready", 32'(vif.ready_o), 32'd1);
      rst_i = 1'b1;
      repeat (40) @(negedge clk_i);

      // Randomized mix against the reference model.
      for (int i = 0; i < 120; i++) begin
         logic [31:0] ra, rb;
         ra = pick(); rb = pick();
         issue(3'($urandom_range(0, 7)), ra, rb, 1);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule
